// File: rtl/zx_sram_arbiter_pkg.sv
// Shared types, limits and helpers for the video/CPU SRAM arbiter.
package zx_sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACT  = 2'd1,
        DONE = 2'd2
    } arb_state_e;

    localparam int MIN_ACCESS_CYCLES = 3;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/zx_sram_arbiter_if.sv
// Requester handshake plus SRAM pins of the shared video/CPU memory, bundled for the arbiter.
interface zx_sram_arbiter_if #(
    parameter int NCH = 3,
    parameter int AW  = 19
);
    logic [NCH-1:0]    req;
    logic [NCH-1:0]    we;
    logic [NCH*AW-1:0] addr;
    logic [NCH*8-1:0]  wdata;
    logic [NCH-1:0]    ack;
    logic [7:0]        rdata;
    logic              busy;
    logic [AW-1:0]     va;
    logic [7:0]        vd_i;
    logic [7:0]        vd_o;
    logic              vd_oe;
    logic              n_vrd;
    logic              n_vwr;

    modport slave (
        input  req, we, addr, wdata, vd_i,
        output ack, rdata, busy, va, vd_o, vd_oe, n_vrd, n_vwr
    );

    modport master (
        output req, we, addr, wdata, vd_i,
        input  ack, rdata, busy, va, vd_o, vd_oe, n_vrd, n_vwr
    );
endinterface

// File: rtl/zx_sram_arbiter_rr.sv
// Winner selection for the SRAM arbiter: optional fixed-priority ch0, round-robin for the rest.
module zx_rr_arbiter
    import zx_sram_arb_pkg::*;
#(
    parameter int NCH         = 3,
    parameter int PRIO0_FIXED = 1
) (
    input  logic                    clk28,
    input  logic                    rst_n,
    input  logic [NCH-1:0]          req_i,
    input  logic                    grant_i,
    output logic                    any_o,
    output logic [clog2(NCH)-1:0]   win_o,
    output logic [NCH-1:0]          gnt_oh_o
);
    localparam int IW = clog2(NCH);
    localparam logic [IW-1:0] FIRST_RR = (PRIO0_FIXED != 0) ? IW'(1) : '0;

    logic [IW-1:0]  ptr_q, ptr_d;
    logic [NCH-1:0] elig;
    logic [IW-1:0]  hi_idx, lo_idx;
    logic           hi_found;

    // Scan downward so the last hit kept is the lowest index in each half of the wrap.
    always_comb begin
        elig = req_i;
        if (PRIO0_FIXED != 0) elig[0] = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        hi_found = 1'b0;
        for (int j = NCH - 1; j >= 0; j--) begin
            if (elig[j]) begin
                if (IW'(j) >= ptr_q) begin
                    hi_idx   = IW'(j);
                    hi_found = 1'b1;
                end else begin
                    lo_idx = IW'(j);
                end
            end
        end
        any_o = |req_i;
        if (PRIO0_FIXED != 0 && req_i[0]) win_o = '0;
        else if (hi_found)                win_o = hi_idx;
        else                              win_o = lo_idx;
        gnt_oh_o = '0;
        if (any_o) gnt_oh_o[win_o] = 1'b1;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_i && any_o && !(PRIO0_FIXED != 0 && win_o == '0)) begin
            if (win_o == IW'(NCH - 1)) ptr_d = FIRST_RR;
            else                       ptr_d = win_o + IW'(1);
        end
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) ptr_q <= FIRST_RR;
        else        ptr_q <= ptr_d;
    end
endmodule

// File: rtl/zx_sram_arbiter.sv
// Shared video/CPU SRAM arbiter and access sequencer: one SRAM access at a time, req/ack per channel.
// state | meaning
// IDLE  | no access; winner picked and request latched when any req is high
// ACT   | SRAM access in progress, cnt counts ACCESS_CYCLES-1 down to 0
// DONE  | one-cycle ack to the latched winner, strobes released
module zx_sram_arbiter
    import zx_sram_arb_pkg::*;
#(
    parameter int NCH           = 3,
    parameter int AW            = 19,
    parameter int ACCESS_CYCLES = 4,
    parameter int PRIO0_FIXED   = 1
) (
    input  logic              clk28,
    input  logic              rst_n,
    zx_sram_arbiter_if.slave  bus
);
    localparam int IW = clog2(NCH);
    localparam int CW = clog2(ACCESS_CYCLES);
    localparam logic [CW-1:0] CNT_LOAD = CW'(ACCESS_CYCLES - 1);
    localparam logic [CW-1:0] WR_LAST  = CW'(ACCESS_CYCLES - 2);

    if (NCH < 2 || NCH > 8 || ACCESS_CYCLES < MIN_ACCESS_CYCLES) begin : g_param_check
        $error("zx_sram_arbiter: NCH must be 2..8 and ACCESS_CYCLES >= %0d", MIN_ACCESS_CYCLES);
    end

    arb_state_e     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [NCH-1:0] win_oh_q, win_oh_d;
    logic           we_q, we_d;
    logic [AW-1:0]  va_q, va_d;
    logic [7:0]     wdata_q, wdata_d;
    logic [7:0]     rdata_q, rdata_d;
    logic           grant;
    logic           any_req;
    logic [IW-1:0]  win;
    logic [NCH-1:0] gnt_oh;

    zx_rr_arbiter #(
        .NCH         (NCH),
        .PRIO0_FIXED (PRIO0_FIXED)
    ) u_rr (
        .clk28    (clk28),
        .rst_n    (rst_n),
        .req_i    (bus.req),
        .grant_i  (grant),
        .any_o    (any_req),
        .win_o    (win),
        .gnt_oh_o (gnt_oh)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        win_oh_d = win_oh_q;
        we_d     = we_q;
        va_d     = va_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        grant    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant    = 1'b1;
                    state_d  = ACT;
                    cnt_d    = CNT_LOAD;
                    win_oh_d = gnt_oh;
                    we_d     = bus.we[win];
                    va_d     = bus.addr[int'(win)*AW +: AW];
                    wdata_d  = bus.wdata[int'(win)*8 +: 8];
                end
            end
            ACT: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    if (!we_q) rdata_d = bus.vd_i;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            win_oh_q <= '0;
            we_q     <= 1'b0;
            va_q     <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            win_oh_q <= win_oh_d;
            we_q     <= we_d;
            va_q     <= va_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
        end
    end

    // Write strobe skips the first and last ACT cycles to give address/data setup and hold.
    assign bus.n_vwr = !(state_q == ACT && we_q && cnt_q != '0 && cnt_q <= WR_LAST);
    assign bus.n_vrd = !(state_q == ACT && !we_q);
    assign bus.vd_oe = (state_q == ACT) && we_q;
    assign bus.vd_o  = wdata_q;
    assign bus.va    = va_q;
    assign bus.rdata = rdata_q;
    assign bus.busy  = (state_q != IDLE);
    assign bus.ack   = (state_q == DONE) ? win_oh_q : '0;
endmodule

// File: tb/tb_zx_sram_arbiter.sv
// Scoreboard bench: two arbiter instances (fixed ch0 priority / full round-robin) on 64K RAM models.
`timescale 1ns/10ps
module tb_zx_sram_arbiter;
    logic clk28 = 1'b0;
    logic rst_n = 1'b0;
    always #17.85 clk28 = ~clk28;

    zx_sram_arbiter_if #(.NCH(3), .AW(19)) bus_a ();
    zx_sram_arbiter_if #(.NCH(3), .AW(19)) bus_b ();

    zx_sram_arbiter #(.NCH(3), .AW(19), .ACCESS_CYCLES(4), .PRIO0_FIXED(1))
        dut_a (.clk28(clk28), .rst_n(rst_n), .bus(bus_a));
    zx_sram_arbiter #(.NCH(3), .AW(19), .ACCESS_CYCLES(6), .PRIO0_FIXED(0))
        dut_b (.clk28(clk28), .rst_n(rst_n), .bus(bus_b));

    logic [2:0]  req_a = '0, we_a = '0, req_b = '0, we_b = '0;
    logic [56:0] addr_a = '0, addr_b = '0;
    logic [23:0] wd_a = '0, wd_b = '0;
    assign bus_a.req = req_a;  assign bus_a.we = we_a;
    assign bus_a.addr = addr_a; assign bus_a.wdata = wd_a;
    assign bus_b.req = req_b;  assign bus_b.we = we_b;
    assign bus_b.addr = addr_b; assign bus_b.wdata = wd_b;

    // RAM models: registered read, write on every edge with n_vwr low, unwritten cells hold a pattern.
    logic [7:0] mem_a [0:65535];
    logic [7:0] mem_b [0:65535];
    bit         val_a [0:65535];
    bit         val_b [0:65535];
    logic [7:0] vdi_a = '0, vdi_b = '0;
    assign bus_a.vd_i = vdi_a;
    assign bus_b.vd_i = vdi_b;

    function automatic logic [7:0] dflt(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    always @(posedge clk28) begin
        vdi_a <= val_a[bus_a.va[15:0]] ? mem_a[bus_a.va[15:0]] : dflt(bus_a.va[15:0]);
        vdi_b <= val_b[bus_b.va[15:0]] ? mem_b[bus_b.va[15:0]] : dflt(bus_b.va[15:0]);
        if (!bus_a.n_vwr) begin
            mem_a[bus_a.va[15:0]] <= bus_a.vd_o;
            val_a[bus_a.va[15:0]] <= 1'b1;
        end
        if (!bus_b.n_vwr) begin
            mem_b[bus_b.va[15:0]] <= bus_b.vd_o;
            val_b[bus_b.va[15:0]] <= 1'b1;
        end
    end

    int cyc = 0, nwr_a = 0, nrd_b = 0, ackn_a = 0;
    always @(posedge clk28) cyc <= cyc + 1;
    always @(negedge clk28) begin
        if (!bus_a.n_vwr) nwr_a <= nwr_a + 1;
        if (!bus_b.n_vrd) nrd_b <= nrd_b + 1;
        if (bus_a.ack != '0) ackn_a <= ackn_a + 1;
    end

    typedef struct {
        int         ch;
        bit         chk_data;
        logic [7:0] data;
        int         cyc;
    } exp_t;
    exp_t q_a[$];
    exp_t q_b[$];
    int errors = 0, checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_ack(input int d, input int ch, input bit cd, input logic [7:0] data, input int c);
        exp_t e;
        e.ch = ch; e.chk_data = cd; e.data = data; e.cyc = c;
        if (d == 0) q_a.push_back(e);
        else        q_b.push_back(e);
    endtask

    task automatic mon(input int d, input logic [2:0] ack, input logic [7:0] rd);
        exp_t e;
        bit   have;
        have = 1'b0;
        if (d == 0 && q_a.size() > 0) begin e = q_a.pop_front(); have = 1'b1; end
        if (d == 1 && q_b.size() > 0) begin e = q_b.pop_front(); have = 1'b1; end
        if (!have) begin
            chk($sformatf("ack_unexpected_dut%0d", d), {29'b0, ack}, 32'd0);
            return;
        end
        chk($sformatf("ack_channel_dut%0d", d), {29'b0, ack}, 32'd1 << e.ch);
        if (e.chk_data) chk($sformatf("rdata_dut%0d_ch%0d", d, e.ch), {24'b0, rd}, {24'b0, e.data});
        if (e.cyc >= 0) chk($sformatf("ack_cycle_dut%0d_ch%0d", d, e.ch), cyc, e.cyc);
    endtask

    always @(negedge clk28) begin
        if (bus_a.ack != '0) mon(0, bus_a.ack, bus_a.rdata);
        if (bus_b.ack != '0) mon(1, bus_b.ack, bus_b.rdata);
    end

    task automatic sync();
        @(posedge clk28);
        #1;
    endtask

    // Requester: raise req with its request, drop it at the sample where ack is seen.
    task automatic issue(input int d, input int ch, input bit w, input logic [18:0] a, input logic [7:0] wd);
        logic [2:0] ack;
        if (d == 0) begin
            we_a[ch] = w; addr_a[ch*19 +: 19] = a; wd_a[ch*8 +: 8] = wd; req_a[ch] = 1'b1;
        end else begin
            we_b[ch] = w; addr_b[ch*19 +: 19] = a; wd_b[ch*8 +: 8] = wd; req_b[ch] = 1'b1;
        end
        ack = '0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk28);
            ack = (d == 0) ? bus_a.ack : bus_b.ack;
            if (ack[ch]) break;
        end
        if (!ack[ch]) chk($sformatf("ack_timeout_dut%0d_ch%0d", d, ch), {29'b0, ack}, 32'd1 << ch);
        if (d == 0) req_a[ch] = 1'b0;
        else        req_b[ch] = 1'b0;
    endtask

    task automatic chk_idle(input string tag, input logic [2:0] ack, input logic [7:0] rd,
                            input logic busy, input logic [18:0] va, input logic [7:0] vdo,
                            input logic oe, input logic nrd, input logic nwr);
        chk({tag, "_ack"},   {29'b0, ack}, 32'd0);
        chk({tag, "_rdata"}, {24'b0, rd},  32'd0);
        chk({tag, "_busy"},  {31'b0, busy}, 32'd0);
        chk({tag, "_va"},    {13'b0, va},  32'd0);
        chk({tag, "_vd_o"},  {24'b0, vdo}, 32'd0);
        chk({tag, "_vd_oe"}, {31'b0, oe},  32'd0);
        chk({tag, "_n_vrd"}, {31'b0, nrd}, 32'd1);
        chk({tag, "_n_vwr"}, {31'b0, nwr}, 32'd1);
    endtask

    initial begin
        int n0, a0, c;
        #5;
        chk_idle("rst_a", bus_a.ack, bus_a.rdata, bus_a.busy, bus_a.va, bus_a.vd_o,
                 bus_a.vd_oe, bus_a.n_vrd, bus_a.n_vwr);
        chk_idle("rst_b", bus_b.ack, bus_b.rdata, bus_b.busy, bus_b.va, bus_b.vd_o,
                 bus_b.vd_oe, bus_b.n_vrd, bus_b.n_vwr);
        repeat (2) @(posedge clk28);
        #3 rst_n = 1'b1;

        // Single write then read back on ch1.
        sync();
        n0 = nwr_a;
        expect_ack(0, 1, 1'b0, 8'h00, cyc + 5);
        issue(0, 1, 1'b1, 19'h01234, 8'hA5);
        chk("t1_n_vwr_low_cycles", nwr_a - n0, 32'd2);
        sync();
        expect_ack(0, 1, 1'b1, 8'hA5, cyc + 5);
        issue(0, 1, 1'b0, 19'h01234, 8'h00);

        // Simultaneous ch0/ch1: fixed-priority ch0 first.
        sync();
        c  = cyc;
        a0 = ackn_a;
        expect_ack(0, 0, 1'b1, 8'h2C, c + 5);
        expect_ack(0, 1, 1'b1, 8'hA5, c + 11);
        fork
            issue(0, 0, 1'b0, 19'h00010, 8'h00);
            issue(0, 1, 1'b0, 19'h01234, 8'h00);
        join
        repeat (4) @(negedge clk28);
        chk("t2_ack_pulses", ackn_a - a0, 32'd2);

        // Inputs change during ACT; only the latched request reaches the SRAM.
        sync();
        expect_ack(0, 2, 1'b0, 8'h00, cyc + 5);
        fork
            issue(0, 2, 1'b1, 19'h00200, 8'h55);
            begin
                sync();
                sync();
                addr_a[2*19 +: 19] = 19'h00300;
                wd_a[23:16]        = 8'hAA;
                #5;
                chk("t6_va_latched",   {13'b0, bus_a.va},   32'h200);
                chk("t6_vd_o_latched", {24'b0, bus_a.vd_o}, 32'h55);
            end
        join
        sync();
        expect_ack(0, 2, 1'b1, 8'h55, cyc + 5);
        issue(0, 2, 1'b0, 19'h00200, 8'h00);
        sync();
        expect_ack(0, 2, 1'b1, 8'h3F, cyc + 5);
        issue(0, 2, 1'b0, 19'h00300, 8'h00);

        // Reset in the second ACT cycle of a write to 0x00FF.
        sync();
        a0 = ackn_a;
        we_a[1] = 1'b1; addr_a[19 +: 19] = 19'h000FF; wd_a[15:8] = 8'h99; req_a[1] = 1'b1;
        @(posedge clk28);
        @(posedge clk28);
        #5;
        chk("t4_n_vwr_active", {31'b0, bus_a.n_vwr}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk_idle("t4_rst", bus_a.ack, bus_a.rdata, bus_a.busy, bus_a.va, bus_a.vd_o,
                 bus_a.vd_oe, bus_a.n_vrd, bus_a.n_vwr);
        req_a[1] = 1'b0;
        @(posedge clk28);
        @(negedge clk28);
        rst_n = 1'b1;
        repeat (6) @(negedge clk28);
        chk("t4_no_ack", ackn_a - a0, 32'd0);
        sync();
        expect_ack(0, 1, 1'b1, 8'hC3, cyc + 5);
        issue(0, 1, 1'b0, 19'h000FF, 8'h00);

        // Six-cycle read of the top address.
        sync();
        n0 = nrd_b;
        expect_ack(1, 2, 1'b1, 8'h3C, cyc + 7);
        issue(1, 2, 1'b0, 19'h7FFFF, 8'h00);
        chk("t5_n_vrd_low_cycles", nrd_b - n0, 32'd6);
        chk("t5_va_full_width", {13'b0, bus_b.va}, 32'h7FFFF);

        // Full round-robin with all channels requesting continuously.
        sync();
        c = cyc + 1;
        expect_ack(1, 0, 1'b1, 8'h3D, c + 6);
        expect_ack(1, 1, 1'b1, 8'h3E, c + 14);
        expect_ack(1, 2, 1'b1, 8'h3F, c + 22);
        expect_ack(1, 0, 1'b1, 8'h3D, c + 30);
        expect_ack(1, 1, 1'b1, 8'h3E, c + 38);
        expect_ack(1, 2, 1'b1, 8'h3F, c + 46);
        fork
            repeat (2) issue(1, 0, 1'b0, 19'h00100, 8'h00);
            repeat (2) issue(1, 1, 1'b0, 19'h00200, 8'h00);
            repeat (2) issue(1, 2, 1'b0, 19'h00300, 8'h00);
        join

        repeat (10) @(negedge clk28);
        chk("queue_a_drained", q_a.size(), 32'd0);
        chk("queue_b_drained", q_b.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
